bin2bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter controller. Runs the shift/add-3 (double-dabble) algorithm one bit per

---
 rtl/bin2bcd_pkg.sv | 35 +++
 rtl/bin2bcd_if.sv | 32 +++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bin2bcd_seq.sv | 122 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_pkg
// Brief  : Shared types, constants and the digit-count helper for bin2bcd_seq.
// Rev    : 1.0
// ============================================================================
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

    // Smallest digit count whose decimal range covers 2**width-1.
    function automatic int ndig_min(input int width);
        longint unsigned max_v;
        longint unsigned pow10;
        int              n;
        max_v = (64'd1 << width) - 64'd1;
        pow10 = 64'd10;
        n     = 1;
        while (pow10 <= max_v) begin
            n     = n + 1;
            pow10 = pow10 * 64'd10;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_if.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_if
// Brief  : Input/output handshake bundle of bin2bcd_seq (blank only with BIN2BCD_BLANK_EN).
// Rev    : 1.0
// ============================================================================
interface bin2bcd_if #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    bin;
    logic                out_valid;
    logic                out_ready;
    logic [4*NDIG-1:0]   bcd;
    logic                busy;
`ifdef BIN2BCD_BLANK_EN
    logic [NDIG-1:0]     blank;

    modport master (output in_valid, bin, out_ready,
                    input  in_ready, out_valid, bcd, busy, blank);
    modport slave  (input  in_valid, bin, out_ready,
                    output in_ready, out_valid, bcd, busy, blank);
`else
    modport master (output in_valid, bin, out_ready,
                    input  in_ready, out_valid, bcd, busy);
    modport slave  (input  in_valid, bin, out_ready,
                    output in_ready, out_valid, bcd, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit_adj
// Brief  : Double-dabble digit correction: add 3 when the digit is 5 or more.
// Rev    : 1.0
// ============================================================================
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);
    // Wraps within 4 bits; inputs never exceed 9 so no carry is lost.
    assign dout = (din >= DIGIT_W'(ADJ_THRESH)) ? din + DIGIT_W'(ADJ_ADD) : din;
endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_seq
// Brief  : One-bit-per-clock double-dabble converter with ready/valid ports.
//          Optional BIN2BCD_BLANK_EN adds a registered leading-zero blank mask.
// Rev    : 1.0
// ============================================================================
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    bin2bcd_if.slave       bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = DIGIT_W * NDIG;

    if (NDIG < ndig_min(WIDTH)) begin : g_ndig_check
        $error("bin2bcd_seq: NDIG=%0d too small for WIDTH=%0d", NDIG, WIDTH);
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   sr_q,    sr_d;
    logic [BCD_W-1:0]   dig_q,   dig_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [BCD_W-1:0]   dig_adj;

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (dig_q[i*DIGIT_W +: DIGIT_W]),
            .dout (dig_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BIN2BCD_BLANK_EN
    logic [NDIG-1:0] blank_q, blank_d, blank_next;
    logic            upper_zero;

    // Walk from the top digit down; digit 0 is never blanked.
    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            upper_zero    = upper_zero && (dig_q[i*DIGIT_W +: DIGIT_W] == '0);
            blank_next[i] = upper_zero;
        end
    end

    assign bus.blank = blank_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        dig_d   = dig_q;
        bcd_d   = bcd_q;
`ifdef BIN2BCD_BLANK_EN
        blank_d = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SHIFT;
                    sr_d    = bus.bin;
                    dig_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // One extra cycle after the last shift to latch the result.
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = DONE;
                    bcd_d   = dig_q;
`ifdef BIN2BCD_BLANK_EN
                    blank_d = blank_next;
`endif
                end else begin
                    {dig_d, sr_d} = {dig_adj, sr_q} << 1;
                    cnt_d         = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dig_q   <= '0;
            bcd_q   <= '0;
`ifdef BIN2BCD_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dig_q   <= dig_d;
            bcd_q   <= bcd_d;
`ifdef BIN2BCD_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == SHIFT) || (state_q == DONE);
    assign bus.bcd       = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_bin2bcd_seq
// Brief  : Directed self-checking bench for bin2bcd_seq (WIDTH=8, NDIG=3).
// Rev    : 1.0
// ============================================================================
module tb_bin2bcd_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    bin2bcd_if #(.WIDTH(8), .NDIG(3)) bus ();

    bin2bcd_seq #(.WIDTH(8), .NDIG(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand at a negedge; returns at the negedge after the accept edge.
    task automatic start(input logic [7:0] v);
        bus.bin      = v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen; lat=-1 on timeout.
    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        lat = bus.out_valid ? n : -1;
        if (lat < 0) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: out_valid not seen within 40 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.bin       = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.bcd} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
            n_err++;
            $display("FAIL reset: rdy/vld/busy/bcd=%b/%b/%b/%h required 1/0/0/000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.bcd);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_latency();
        int lat;
        bus.out_ready = 1'b1;
        start(8'd0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 9) begin
            n_err++; $display("FAIL latency: got %0d required 9", lat);
        end
        n_cmp++;
        if (bus.bcd !== 12'h000) begin
            n_err++; $display("FAIL zero: bcd=%h required 000", bus.bcd);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pulse: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_values();
        logic [7:0]  vin [3] = '{8'd255, 8'd99, 8'd100};
        logic [11:0] vexp[3] = '{12'h255, 12'h099, 12'h100};
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start(vin[i]);
            wait_valid(lat);
            n_cmp++;
            if (bus.bcd !== vexp[i]) begin
                n_err++; $display("FAIL value %0d: bcd=%h required %h", vin[i], bus.bcd, vexp[i]);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        start(8'd100);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.busy, bus.bcd} !== {1'b1, 1'b0, 1'b1, 12'h100}) begin
                n_err++;
                $display("FAIL hold %0d: vld/rdy/busy/bcd=%b/%b/%b/%h required 1/0/1/100",
                         i, bus.out_valid, bus.in_ready, bus.busy, bus.bcd);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        bus.out_ready = 1'b1;
        bus.bin       = 8'd5;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bin = 8'd77;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL shift flags: in_ready=%b busy=%b required 0/1", bus.in_ready, bus.busy);
        end
        wait_valid(lat);
        n_cmp++;
        if (bus.bcd !== 12'h005 || lat !== 9) begin
            n_err++; $display("FAIL ignore: bcd=%h lat=%0d required 005/9", bus.bcd, lat);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL after hs: in_ready=%b busy=%b required 1/0", bus.in_ready, bus.busy);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        n_cmp++;
        if (bus.bcd !== 12'h077 || lat !== 9) begin
            n_err++; $display("FAIL recapture: bcd=%h lat=%0d required 077/9", bus.bcd, lat);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.out_ready = 1'b1;
        start(8'd200);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.bcd} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
            n_err++;
            $display("FAIL mid reset: rdy/busy/vld/bcd=%b/%b/%b/%h required 1/0/0/000",
                     bus.in_ready, bus.busy, bus.out_valid, bus.bcd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen || bus.in_ready !== 1'b1 || bus.bcd !== 12'h000) begin
            n_err++;
            $display("FAIL post reset: seen_valid=%b in_ready=%b bcd=%h required 0/1/000",
                     seen, bus.in_ready, bus.bcd);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [11:0] exp_bcd;
        bus.out_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b ready %0d: in_ready=%b required 1", v, bus.in_ready);
            end
            start(8'(v));
            wait_valid(lat);
            n_cmp++;
            if (bus.bcd !== exp_bcd || lat !== 9) begin
                n_err++; $display("FAIL b2b %0d: bcd=%h lat=%0d required %h/9", v, bus.bcd, lat, exp_bcd);
            end
`ifdef BIN2BCD_BLANK_EN
            n_cmp++;
            if (bus.blank !== {exp_bcd[11:8] == 4'd0, exp_bcd[11:4] == 8'd0, 1'b0}) begin
                n_err++; $display("FAIL b2b blank %0d: blank=%b", v, bus.blank);
            end
`endif
            @(posedge clk);
            @(negedge clk);
        end
    endtask

`ifdef BIN2BCD_BLANK_EN
    task automatic test_blank();
        logic [7:0] vin [4] = '{8'd7, 8'd40, 8'd0, 8'd255};
        logic [2:0] vexp[4] = '{3'b110, 3'b100, 3'b110, 3'b000};
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start(vin[i]);
            wait_valid(lat);
            n_cmp++;
            if (bus.blank !== vexp[i]) begin
                n_err++; $display("FAIL blank %0d: blank=%b required %b", vin[i], bus.blank, vexp[i]);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_zero_latency();
        test_values();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid();
        test_back_to_back();
`ifdef BIN2BCD_BLANK_EN
        test_blank();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
